// File: rtl/cpu_pkg.sv
// Shared definitions for the step sequencer and the control FSM:
// one-hot step encodings, opcodes and the step width.
package cpu_pkg;

    localparam int STEP_W = 8;

    typedef enum logic [STEP_W-1:0] {
        S_IDLE = 8'h00,
        S0     = 8'h01,
        S1     = 8'h02,
        S2     = 8'h04,
        S3     = 8'h08,
        S_HALT = 8'h80
    } step_t;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // The opcode is only valid in S1, so its class is latched for use in S2.
    typedef enum logic [1:0] {
        K_ADD = 2'd0,
        K_LW  = 2'd1,
        K_SW  = 2'd2
    } kind_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: taken branch adds the signed offset, otherwise step.
module pc_next #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        is_beq,
    input  logic        zero,
    output logic [31:0] pc_nxt
);

    // Two's complement add modulo 2^32 handles negative offsets and wrap.
    assign pc_nxt = (is_beq && zero) ? (pc + imm) : (pc + PC_STEP);

endmodule

// File: rtl/cpu_step_sequencer.sv
// One-hot step sequencer: fetch/decode/memory/writeback walk, PC and
// retired-instruction counter, with stalls on memory handshakes.
//
// state  | meaning
// S_IDLE | waiting for run
// S0     | fetch, waits for mem_ready
// S1     | decode/execute, beq retires here
// S2     | memory: add passes through, lw/sw wait for mem_ready
// S3     | writeback, retires
// S_HALT | unknown opcode, only reset leaves
module cpu_step_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [6:0]        OpI,
    input  logic              zero,
    input  logic [31:0]       imm,
    input  logic              mem_ready,
    output logic [STEP_W-1:0] S,
    output logic [31:0]       PC,
    output logic              mem_req,
    output logic              halted,
    output logic [15:0]       instr_cnt
);

    step_t       state, state_nxt;
    kind_t       kind, kind_nxt;
    logic        retire;
    logic        mem_req_nxt;
    logic        is_beq;
    logic [31:0] pc_cand;

    assign S      = state;
    assign is_beq = (state == S1) && (OpI == OP_BEQ);

    pc_next #(.PC_STEP(PC_STEP)) u_pc_next (
        .pc     (PC),
        .imm    (imm),
        .is_beq (is_beq),
        .zero   (zero),
        .pc_nxt (pc_cand)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            kind      <= K_ADD;
            PC        <= RESET_PC;
            mem_req   <= 1'b0;
            halted    <= 1'b0;
            instr_cnt <= 16'd0;
        end else begin
            state   <= state_nxt;
            kind    <= kind_nxt;
            mem_req <= mem_req_nxt;
            halted  <= (state_nxt == S_HALT);
            if (retire) begin
                PC        <= pc_cand;
                instr_cnt <= instr_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        retire    = 1'b0;
        case (state)
            S_IDLE: if (run) state_nxt = S0;
            S0:     if (mem_ready) state_nxt = S1;
            S1: begin
                case (OpI)
                    OP_ADD: begin kind_nxt = K_ADD; state_nxt = S2; end
                    OP_LW:  begin kind_nxt = K_LW;  state_nxt = S2; end
                    OP_SW:  begin kind_nxt = K_SW;  state_nxt = S2; end
                    OP_BEQ: retire = 1'b1;
                    default: state_nxt = S_HALT;
                endcase
            end
            S2: begin
                case (kind)
                    K_ADD:   state_nxt = S3;
                    K_LW:    if (mem_ready) state_nxt = S3;
                    K_SW:    if (mem_ready) retire = 1'b1;
                    default: state_nxt = S_HALT;
                endcase
            end
            S3:     retire = 1'b1;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        if (retire) state_nxt = run ? S0 : S_IDLE;
    end

    // Registered so mem_req rises with entry into S0 / lw-sw S2 and falls on exit.
    always_comb begin
        mem_req_nxt = (state_nxt == S0) ||
                      ((state_nxt == S2) && (kind_nxt != K_ADD));
    end

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed self-checking bench for cpu_step_sequencer.
module tb_cpu_step_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [6:0]  OpI;
    logic        zero;
    logic [31:0] imm;
    logic        mem_ready;
    logic [7:0]  S;
    logic [31:0] PC;
    logic        mem_req;
    logic        halted;
    logic [15:0] instr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_step_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .OpI       (OpI),
        .zero      (zero),
        .imm       (imm),
        .mem_ready (mem_ready),
        .S         (S),
        .PC        (PC),
        .mem_req   (mem_req),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; OpI = 7'd0; zero = 1'b0;
        imm = 32'd0; mem_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (S !== 8'h00) begin n_fail++; $display("FAIL reset_S got %h want 00", S); end
        n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_PC got %h want 0", PC); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_checks++; if (instr_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", instr_cnt); end
    endtask

    // add then lw back-to-back; lw stalls 3 cycles in S2
    task automatic test_add_lw();
        logic [7:0] add_s[5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
        logic       add_m[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        run = 1'b1; mem_ready = 1'b1; OpI = OP_ADD;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (S !== add_s[i]) begin n_fail++; $display("FAIL add_S[%0d] got %h want %h", i, S, add_s[i]); end
            n_checks++; if (mem_req !== add_m[i]) begin n_fail++; $display("FAIL add_mem_req[%0d] got %b want %b", i, mem_req, add_m[i]); end
        end
        n_checks++; if (PC !== 32'h4) begin n_fail++; $display("FAIL add_PC got %h want 4", PC); end
        n_checks++; if (instr_cnt !== 16'd1) begin n_fail++; $display("FAIL add_cnt got %0d want 1", instr_cnt); end
        OpI = OP_LW;
        tick();
        n_checks++; if (S !== 8'h02) begin n_fail++; $display("FAIL lw_S1 got %h want 02", S); end
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (S !== 8'h04 || mem_req !== 1'b1) begin n_fail++; $display("FAIL lw_wait[%0d] S %h mem_req %b want 04/1", i, S, mem_req); end
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        n_checks++; if (S !== 8'h08 || mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_S3 S %h mem_req %b want 08/0", S, mem_req); end
        tick();
        n_checks++; if (S !== 8'h01 || PC !== 32'h8 || instr_cnt !== 16'd2) begin n_fail++; $display("FAIL lw_retire S %h PC %h cnt %0d want 01/8/2", S, PC, instr_cnt); end
    endtask

    task automatic test_beq();
        logic [31:0] imm_v[4]  = '{32'h10, 32'hFFFF_FFF8, 32'h8, 32'h100};
        logic        zero_v[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] pc_v[4]   = '{32'h10, 32'h08, 32'h10, 32'h14};
        do_reset();
        run = 1'b1; mem_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (S !== 8'h01) begin n_fail++; $display("FAIL beq_S0[%0d] got %h want 01", i, S); end
            OpI = OP_BEQ; imm = imm_v[i]; zero = zero_v[i];
            tick();
            n_checks++; if (S !== 8'h02) begin n_fail++; $display("FAIL beq_S1[%0d] got %h want 02", i, S); end
            tick();
            n_checks++; if (PC !== pc_v[i] || instr_cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL beq_PC[%0d] PC %h cnt %0d want %h/%0d", i, PC, instr_cnt, pc_v[i], i + 1); end
        end
    endtask

    task automatic test_sw_wrap();
        do_reset();
        run = 1'b1; mem_ready = 1'b1;
        tick();
        OpI = OP_BEQ; imm = 32'hFFFF_FFFC; zero = 1'b1;
        tick(); tick();
        n_checks++; if (S !== 8'h01 || PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sw_setup S %h PC %h want 01/fffffffc", S, PC); end
        OpI = OP_SW; zero = 1'b0;
        tick(); tick();
        n_checks++; if (S !== 8'h04 || mem_req !== 1'b1) begin n_fail++; $display("FAIL sw_S2 S %h mem_req %b want 04/1", S, mem_req); end
        tick();
        n_checks++; if (S !== 8'h01 || PC !== 32'h0 || instr_cnt !== 16'd2) begin n_fail++; $display("FAIL sw_wrap S %h PC %h cnt %0d want 01/0/2", S, PC, instr_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; OpI = OP_ADD;
        repeat (5) tick();
        OpI = 7'b1111111;
        tick(); tick();
        n_checks++; if (S !== 8'h80 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter S %h halted %b want 80/1", S, halted); end
        n_checks++; if (PC !== 32'h4 || instr_cnt !== 16'd1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL halt_regs PC %h cnt %0d mem_req %b want 4/1/0", PC, instr_cnt, mem_req); end
        OpI = OP_ADD;
        tick(); tick();
        n_checks++; if (S !== 8'h80) begin n_fail++; $display("FAIL halt_stay got %h want 80", S); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (S !== 8'h00 || PC !== 32'h0 || halted !== 1'b0 || instr_cnt !== 16'd0) begin n_fail++; $display("FAIL halt_reset S %h PC %h halted %b cnt %0d want 00/0/0/0", S, PC, halted, instr_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_run_drop();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; OpI = OP_ADD;
        tick(); tick(); tick();
        run = 1'b0;
        tick();
        n_checks++; if (S !== 8'h08) begin n_fail++; $display("FAIL drop_S3 got %h want 08", S); end
        tick();
        n_checks++; if (S !== 8'h00 || PC !== 32'h4 || instr_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_idle S %h PC %h cnt %0d want 00/4/1", S, PC, instr_cnt); end
        tick();
        n_checks++; if (S !== 8'h00 || mem_req !== 1'b0) begin n_fail++; $display("FAIL drop_stay S %h mem_req %b want 00/0", S, mem_req); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        run = 1'b1; mem_ready = 1'b0;
        tick(); tick();
        n_checks++; if (S !== 8'h01 || mem_req !== 1'b1) begin n_fail++; $display("FAIL wait_S0 S %h mem_req %b want 01/1", S, mem_req); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (S !== 8'h00 || mem_req !== 1'b0) begin n_fail++; $display("FAIL wait_reset S %h mem_req %b want 00/0", S, mem_req); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add_lw();
        test_beq();
        test_sw_wrap();
        test_halt();
        test_run_drop();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
